drm_metering_event_scheduler: RTL and testbench



---
 rtl/drm_metering_event_scheduler.sv | 125 ++++++++++++
 tb/tb_drm_metering_event_scheduler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/drm_metering_event_scheduler.sv
// Round-robin scheduler that serializes per-CU metering events into spaced single-cycle pulses.
// Optional macro DRM_METERING_TOTAL_EN enables the 32-bit issued-pulse counter on metering_total.
//
// state | meaning
// IDLE  | waiting for a pending event; grants the round-robin winner
// PULSE | metering_event high for this single cycle
// GAP   | enforced low spacing of EVENT_GAP cycles
module drm_metering_event_scheduler #(
    parameter int NUM_CU    = 4,
    parameter int CNT_W     = 8,
    parameter int EVENT_GAP = 1
) (
    input  logic              ip_core_aclk,
    input  logic              ip_core_arstn,
    input  logic [NUM_CU-1:0] cu_event,
    output logic              metering_event,
    output logic [NUM_CU-1:0] cu_overflow,
    output logic              pending_any,
    output logic [31:0]       metering_total
);
    localparam int RR_W  = $clog2(NUM_CU);
    localparam int GAP_W = (EVENT_GAP > 1) ? $clog2(EVENT_GAP) : 1;

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  pend_q [NUM_CU];
    logic [CNT_W-1:0]  pend_d [NUM_CU];
    logic [NUM_CU-1:0] ovf_d;
    logic [RR_W-1:0]   rr_q, rr_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              grant_vld, do_grant, any_d;
    logic [RR_W-1:0]   grant_idx;
    logic [RR_W-1:0]   gnt_q;

    // Scan from the highest offset down so the offset closest to rr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = NUM_CU - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(rr_q) + k) % NUM_CU;
            if (pend_q[idx] != '0) begin
                grant_vld = 1'b1;
                grant_idx = RR_W'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        do_grant = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    do_grant = 1'b1;
                    state_d  = S_PULSE;
                end
            end
            S_PULSE: begin
                gap_d   = GAP_W'(EVENT_GAP - 1);
                state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_q == '0) state_d = S_IDLE;
                else             gap_d   = gap_q - GAP_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        any_d = 1'b0;
        ovf_d = cu_overflow;
        for (int i = 0; i < NUM_CU; i++) begin
            logic dec;
            dec       = do_grant && (grant_idx == RR_W'(i));
            pend_d[i] = pend_q[i];
            if (cu_event[i] && !dec) begin
                if (pend_q[i] == '1) ovf_d[i]  = 1'b1;
                else                 pend_d[i] = pend_q[i] + CNT_W'(1);
            end else if (!cu_event[i] && dec) begin
                pend_d[i] = pend_q[i] - CNT_W'(1);
            end
            any_d = any_d | (pend_d[i] != '0);
        end
        rr_d = rr_q;
        if (do_grant) rr_d = (grant_idx == RR_W'(NUM_CU - 1)) ? '0 : grant_idx + RR_W'(1);
    end

    always_ff @(posedge ip_core_aclk) begin
        if (!ip_core_arstn) begin
            state_q        <= S_IDLE;
            gap_q          <= '0;
            rr_q           <= '0;
            gnt_q          <= '0;
            cu_overflow    <= '0;
            pending_any    <= 1'b0;
            metering_event <= 1'b0;
            for (int i = 0; i < NUM_CU; i++) pend_q[i] <= '0;
        end else begin
            state_q        <= state_d;
            gap_q          <= gap_d;
            rr_q           <= rr_d;
            cu_overflow    <= ovf_d;
            pending_any    <= any_d;
            metering_event <= do_grant;
            if (do_grant) gnt_q <= grant_idx;
            for (int i = 0; i < NUM_CU; i++) pend_q[i] <= pend_d[i];
        end
    end

`ifdef DRM_METERING_TOTAL_EN
    logic [31:0] total_q;
    always_ff @(posedge ip_core_aclk) begin
        if (!ip_core_arstn)          total_q <= '0;
        else if (state_q == S_PULSE) total_q <= total_q + 32'd1;
    end
    assign metering_total = total_q;
`else
    assign metering_total = '0;
`endif

endmodule

// File: tb/tb_drm_metering_event_scheduler.sv
// Scoreboard bench: stimulus queues expected pulse cycle and granted CU, a monitor pops on each pulse.
module tb_drm_metering_event_scheduler;
    logic       ip_core_aclk = 1'b0;
    logic       ip_core_arstn;
    logic [3:0] cu_event, cu_event_s;
    logic       metering_event, metering_event_s;
    logic [3:0] cu_overflow, cu_overflow_s;
    logic       pending_any, pending_any_s;
    logic [31:0] metering_total, metering_total_s;

    always #5 ip_core_aclk = ~ip_core_aclk;

    drm_metering_event_scheduler #(.NUM_CU(4), .CNT_W(8), .EVENT_GAP(1)) dut (
        .ip_core_aclk(ip_core_aclk), .ip_core_arstn(ip_core_arstn), .cu_event(cu_event),
        .metering_event(metering_event), .cu_overflow(cu_overflow),
        .pending_any(pending_any), .metering_total(metering_total));

    drm_metering_event_scheduler #(.NUM_CU(4), .CNT_W(2), .EVENT_GAP(1)) dut_s (
        .ip_core_aclk(ip_core_aclk), .ip_core_arstn(ip_core_arstn), .cu_event(cu_event_s),
        .metering_event(metering_event_s), .cu_overflow(cu_overflow_s),
        .pending_any(pending_any_s), .metering_total(metering_total_s));

`ifdef DRM_METERING_TOTAL_EN
    localparam bit TOT_EN = 1'b1;
`else
    localparam bit TOT_EN = 1'b0;
`endif

    typedef struct { int cyc; int cu; } exp_t;
    exp_t q0[$];
    exp_t q1[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge ip_core_aclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] exp_tot(input int n);
        return TOT_EN ? 32'(n) : 32'd0;
    endfunction

    task automatic push0(input int c, input int u);
        exp_t e;
        e.cyc = c; e.cu = u;
        q0.push_back(e);
    endtask

    task automatic push1(input int c, input int u);
        exp_t e;
        e.cyc = c; e.cu = u;
        q1.push_back(e);
    endtask

    always @(negedge ip_core_aclk) begin
        exp_t e;
        if (metering_event) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_pulse: got pulse at cycle %0d expected none", cyc);
            end else begin
                e = q0.pop_front();
                chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
                chk("pulse_cu", 32'(dut.gnt_q), 32'(e.cu));
            end
        end
        if (metering_event_s) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_pulse_sat: got pulse at cycle %0d expected none", cyc);
            end else begin
                e = q1.pop_front();
                chk("sat_pulse_cycle", 32'(cyc), 32'(e.cyc));
                chk("sat_pulse_cu", 32'(dut_s.gnt_q), 32'(e.cu));
            end
        end
    end

    task automatic wait_drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
            @(negedge ip_core_aclk);
            n++;
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d/%0d pulses outstanding expected 0", q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
        repeat (6) @(negedge ip_core_aclk);
    endtask

    task automatic do_reset();
        @(negedge ip_core_aclk);
        ip_core_arstn = 1'b0;
        @(negedge ip_core_aclk);
        ip_core_arstn = 1'b1;
    endtask

    initial begin
        int c;
        ip_core_arstn = 1'b0;
        cu_event      = '0;
        cu_event_s    = '0;
        repeat (2) @(negedge ip_core_aclk);
        ip_core_arstn = 1'b1;
        chk("rst_event", {31'd0, metering_event}, 32'd0);
        chk("rst_pending", {31'd0, pending_any}, 32'd0);
        chk("rst_overflow", {28'd0, cu_overflow}, 32'd0);
        chk("rst_total", metering_total, 32'd0);
        chk("rst_sat_pending", {31'd0, pending_any_s}, 32'd0);

        // single event on CU2
        @(negedge ip_core_aclk);
        c = cyc;
        cu_event = 4'b0100;
        push0(c + 2, 2);
        @(negedge ip_core_aclk);
        cu_event = '0;
        chk("single_pending", {31'd0, pending_any}, 32'd1);
        wait_drain();
        chk("single_pending_clr", {31'd0, pending_any}, 32'd0);
        chk("single_overflow", {28'd0, cu_overflow}, 32'd0);
        chk("single_total", metering_total, exp_tot(1));

        // all four CUs at once
        do_reset();
        @(negedge ip_core_aclk);
        c = cyc;
        cu_event = 4'b1111;
        for (int k = 0; k < 4; k++) push0(c + 2 + 3 * k, k);
        @(negedge ip_core_aclk);
        cu_event = '0;
        while (cyc < c + 10) @(negedge ip_core_aclk);
        chk("all4_pending_before_last", {31'd0, pending_any}, 32'd1);
        @(negedge ip_core_aclk);
        chk("all4_pending_after_last", {31'd0, pending_any}, 32'd0);
        wait_drain();
        chk("all4_total", metering_total, exp_tot(4));

        // fairness: CU0 every cycle, CU3 once
        do_reset();
        @(negedge ip_core_aclk);
        c = cyc;
        for (int k = 0; k < 13; k++) push0(c + 2 + 3 * k, (k == 1) ? 3 : 0);
        for (int k = 0; k < 12; k++) begin
            cu_event = (k == 1) ? 4'b1001 : 4'b0001;
            @(negedge ip_core_aclk);
        end
        cu_event = '0;
        wait_drain();
        chk("fair_overflow", {28'd0, cu_overflow}, 32'd0);
        chk("fair_total", metering_total, exp_tot(13));

        // saturation on the CNT_W=2 instance
        do_reset();
        @(negedge ip_core_aclk);
        c = cyc;
        for (int k = 0; k < 10; k++) push1(c + 2 + 3 * k, 1);
        for (int k = 0; k < 20; k++) begin
            cu_event_s = 4'b0010;
            @(negedge ip_core_aclk);
        end
        cu_event_s = '0;
        chk("sat_overflow_set", {28'd0, cu_overflow_s}, 32'h2);
        wait_drain();
        chk("sat_overflow_sticky", {28'd0, cu_overflow_s}, 32'h2);
        chk("sat_pending_clr", {31'd0, pending_any_s}, 32'd0);
        chk("sat_total", metering_total_s, exp_tot(10));
        chk("sat_other_overflow", {28'd0, cu_overflow}, 32'd0);

        // reset while in PULSE with five events pending on CU0
        do_reset();
        @(negedge ip_core_aclk);
        c = cyc;
        push0(c + 2, 0); push0(c + 5, 0); push0(c + 8, 0);
        for (int k = 0; k < 8; k++) begin
            cu_event = 4'b0001;
            @(negedge ip_core_aclk);
        end
        cu_event = '0;
        chk("midrst_pulse_high", {31'd0, metering_event}, 32'd1);
        chk("midrst_pend0", 32'(dut.pend_q[0]), 32'd5);
        ip_core_arstn = 1'b0;
        @(negedge ip_core_aclk);
        ip_core_arstn = 1'b1;
        chk("midrst_event", {31'd0, metering_event}, 32'd0);
        chk("midrst_pending", {31'd0, pending_any}, 32'd0);
        chk("midrst_total", metering_total, 32'd0);
        repeat (20) @(negedge ip_core_aclk);
        wait_drain();
        chk("midrst_quiet", {31'd0, pending_any}, 32'd0);

        // ten events on CU1 for the pulse total
        do_reset();
        @(negedge ip_core_aclk);
        c = cyc;
        for (int k = 0; k < 10; k++) push0(c + 2 + 3 * k, 1);
        for (int k = 0; k < 10; k++) begin
            cu_event = 4'b0010;
            @(negedge ip_core_aclk);
        end
        cu_event = '0;
        wait_drain();
        chk("ten_total", metering_total, exp_tot(10));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
